ula_exec_mc: RTL and testbench



---
 rtl/ula_exec_mc.sv | 153 +++++++++++++++
 tb/tb_ula_exec_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_exec_mc.sv
// ula_exec_mc: multi-cycle execute-stage ALU with valid/ready handshakes.
//
// Sits between ID/EX and EX/MEM. ALU ops are decoded from the 3-bit
// ALUControl code produced by the ALU decoder. ADD/SUB/AND/OR/SLT and the
// unused codes finish one cycle after acceptance. SLL normally shifts one
// bit per cycle. Defining ULA_BARREL_SHIFT_EN makes SLL single-cycle as well,
// and removes the SHIFT state and its counter. Results are identical either
// way; only the latency differs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented
//   in_ready   block can accept an operation (low = pipeline stall)
//   ALUControl operation code
//   SrcA       operand A
//   SrcB       operand B (SrcB[SHAMT_W-1:0] is the SLL shift amount)
//   out_valid  result available
//   out_ready  downstream accepts result
//   ALUResult  registered result
//   Zero       registered, ALUResult == 0
//   illegal    registered, completed op used an unused code
module ula_exec_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5     // must equal $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ALUControl,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifndef ULA_BARREL_SHIFT_EN
        SHIFT = 2'd1,
`endif
        DONE  = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               illegal_q;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res_d;
    logic               illegal_d;

    assign shamt = SrcB[SHAMT_W-1:0];

`ifndef ULA_BARREL_SHIFT_EN
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   acc_d;

    assign acc_d = acc_q << 1;
`endif

    // Single-cycle result for the operation currently presented.
    always_comb begin
        res_d     = '0;
        illegal_d = 1'b0;
        case (ALUControl)
            OP_ADD:  res_d = SrcA + SrcB;
            OP_SUB:  res_d = SrcA - SrcB;
            OP_AND:  res_d = SrcA & SrcB;
            OP_OR:   res_d = SrcA | SrcB;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ULA_BARREL_SHIFT_EN
            OP_SLL:  res_d = SrcA << shamt;
`else
            // Only reaches DONE directly when the shift amount is zero.
            OP_SLL:  res_d = SrcA;
`endif
            default: illegal_d = 1'b1;   // 100 and 111 produce 0
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifndef ULA_BARREL_SHIFT_EN
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifndef ULA_BARREL_SHIFT_EN
                        if (ALUControl == OP_SLL && shamt != '0) begin
                            acc_q   <= SrcA;
                            cnt_q   <= shamt;
                            state_q <= SHIFT;
                        end else
`endif
                        begin
                            result_q  <= res_d;
                            zero_q    <= (res_d == '0);
                            illegal_q <= illegal_d;
                            state_q   <= DONE;
                        end
                    end
                end
`ifndef ULA_BARREL_SHIFT_EN
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    // Last shift: publish the shifted value on this same edge.
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q  <= acc_d;
                        zero_q    <= (acc_d == '0);
                        illegal_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ula_exec_mc.sv
// Scoreboard bench for ula_exec_mc: the driver pushes the model's expected
// result and latency when an op is accepted; a monitor on the falling edge
// pops and compares whenever the DUT presents a result.
module tb_ula_exec_mc;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        ALUControl = 3'b000;
    logic [WIDTH-1:0]  SrcA = '0;
    logic [WIDTH-1:0]  SrcB = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  ALUResult;
    logic              Zero;
    logic              illegal;

    ula_exec_mc #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_valid = 1'b0;
    logic stall = 1'b0;
    logic rand_ready = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the op definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input string nm);
        exp_t        e;
        logic [63:0] p;
        int          n;
        n      = int'(b % 32);
        e.ill  = 1'b0;
        e.lat  = 1;
        e.name = nm;
        e.acc_cyc = 0;
        case (op)
            3'd0: e.res = a + b;
            3'd1: e.res = a - b;
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: begin
                p     = 64'(a) * (64'd1 << n);
                e.res = p[31:0];
`ifndef ULA_BARREL_SHIFT_EN
                e.lat = n + 1;
`endif
            end
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Downstream ready, updated shortly after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(sb.size() == 0));
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                if (!prev_valid)
                    chk({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
                chk({sb[0].name, "_result"}, 64'(ALUResult), 64'(sb[0].res));
                chk({sb[0].name, "_zero"}, 64'(Zero), 64'(sb[0].zero));
                chk({sb[0].name, "_illegal"}, 64'(illegal), 64'(sb[0].ill));
                if (out_ready) void'(sb.pop_front());
            end
            prev_valid <= out_valid;
        end
    end

    // Call at posedge+#1; returns at posedge+#1 just after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready=0 expected 1", nm);
            return;
        end
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        #1;
        e = model(op, a, b, nm);
        e.acc_cyc = cyc;
        sb.push_back(e);
        // Scramble operands: the DUT must have sampled them already.
        in_valid   = 1'b0;
        ALUControl = 3'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: pending=%0d expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset values.
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(ALUResult), 64'd0);
        chk("reset_zero", 64'(Zero), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed ops.
        issue(3'b000, 32'h7FFF_FFFF, 32'h1, "add_ovf");
        issue(3'b001, 32'd5, 32'd5, "sub_zero");
        issue(3'b001, 32'd3, 32'd5, "sub_wrap");
        issue(3'b010, 32'h1234_5678, 32'h0F0F_F0F0, "and");
        issue(3'b011, 32'h1200_0034, 32'h0056_7800, "or");
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        issue(3'b101, 32'd1, 32'hFFFF_FFFF, "slt_pos");
        issue(3'b110, 32'd1, 32'd31, "sll_31");
        issue(3'b110, 32'hA5A5_0001, 32'hFFFF_FFE0, "sll_0");
        issue(3'b110, 32'h8000_0003, 32'd1, "sll_1");
        issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "illegal_111");
        issue(3'b100, 32'hFFFF_FFFF, 32'h1, "illegal_100");
        drain("directed");

        // Backpressure: result held, no accept while DONE.
        stall = 1'b1;
        @(posedge clk);
        #1;
        issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00, "bp_and");
        repeat (5) begin
            in_valid   = 1'b1;
            ALUControl = 3'b000;
            SrcA       = 32'd1;
            SrcB       = 32'd1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_out_valid_held", 64'(out_valid), 64'd1);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_result_held", 64'(ALUResult), 64'h0000_F000);
        stall = 1'b0;
        drain("bp");
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);

        // Reset in the middle of a shift.
        issue(3'b000, 32'h1234_5678, 32'd1, "pre_reset_add");
        drain("pre_reset");
        issue(3'b110, 32'd1, 32'd20, "sll_aborted");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_result", 64'(ALUResult), 64'd0);
        chk("async_rst_zero", 64'(Zero), 64'd0);
        chk("async_rst_illegal", 64'(illegal), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (30) @(posedge clk);
        #1;

        // Randomized ops with random downstream backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom_range(0, 3) : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 31));
            issue(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain("random");
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
